prog_loader: RTL

- Byte-stream program loader: the writer for the byte-addressable instruction memory that the simple CPU fetches from.
- Accepts a framed image on a valid/ready byte stream, typically from a UART receiver. Writes the payload into instruction memory from address 0 upward.
- Verifies a checksum, then releases the CPU from reset.
- Replaces the `$readmemh` preload path for hardware bring-up.

---
 rtl/prog_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: hunts for a sync byte, reads a 16-bit big-endian length,
// writes the payload into instruction memory from address 0 and verifies an 8-bit
// additive checksum before releasing the CPU from reset.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              clear_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic [15:0]       byte_count_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              cpu_rst_n_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrLen  = 2'b01;
  localparam logic [1:0] ErrCsum = 2'b10;

  state_e              state_q;
  logic [15:0]         len_q;
  logic [7:0]          sum_q;
  logic [15:0]         byte_count_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                done_q;
  logic                err_q;
  logic [1:0]          err_code_q;
  logic                in_ready_q;

  logic                accept;
  logic [15:0]         len_full;
  logic                len_over;
  logic [15:0]         count_inc;
  logic [7:0]          sum_next;

  assign accept    = in_valid_i && in_ready_q;
  // Length is complete once the low byte arrives on this cycle.
  assign len_full  = {len_q[15:8], in_data_i};
  assign len_over  = 32'(len_full) > MEM_DEPTH;
  assign count_inc = byte_count_q + 16'd1;
  assign sum_next  = sum_q + in_data_i;

  // Frame FSM with all outputs registered; only accepted bytes or clear advance it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      len_q        <= '0;
      sum_q        <= '0;
      byte_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ErrNone;
      in_ready_q   <= 1'b1;
    end else begin
      // Strobe defaults low so it is high exactly on cycles following a DATA write.
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && in_data_i == SYNC_BYTE) begin
            state_q      <= StLenHi;
            byte_count_q <= '0;
            sum_q        <= '0;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_q[15:8] <= in_data_i;
            state_q     <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_q[7:0] <= in_data_i;
            if (len_over) begin
              state_q    <= StErr;
              err_q      <= 1'b1;
              err_code_q <= ErrLen;
              in_ready_q <= 1'b0;
            end else if (len_full == 16'd0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= byte_count_q[ADDR_W-1:0];
            mem_wdata_q  <= in_data_i;
            byte_count_q <= count_inc;
            sum_q        <= sum_next;
            if (count_inc == len_q) begin
              state_q <= StCsum;
            end
          end
        end
        StCsum: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (sum_next == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StErr;
              err_q      <= 1'b1;
              err_code_q <= ErrCsum;
            end
          end
        end
        StDone, StErr: begin
          if (clear_i) begin
            state_q      <= StIdle;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ErrNone;
            byte_count_q <= '0;
            in_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign byte_count_o = byte_count_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  // CPU stays in reset until a frame has loaded with a good checksum.
  assign cpu_rst_n_o  = done_q;

endmodule
